// File: rtl/nios_debug_slave_sysclk_mc_pkg.sv
// nios_debug_slave_sysclk_mc_pkg: shared widths, channel policy and FSM states for the sysclk debug slave
package nios_debug_slave_sysclk_mc_pkg;
   localparam int SR_W    = 38;
   localparam int IR_W    = 2;
   localparam int N_CH    = 2 ** IR_W;
   localparam int DEPTH   = 4;
   localparam int LVL_W   = $clog2(DEPTH) + 1;
   localparam int ACT_BIT = 34;
   localparam int TMO_W   = 8;
   localparam logic [N_CH-1:0]  ACK_MASK = 4'b0011;
   localparam logic [TMO_W-1:0] TMO      = 8'd255;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
endpackage

// File: rtl/nios_debug_slave_sysclk_mc_if.sv
// nios_debug_slave_sysclk_mc_if: JTAG-event inputs and OCI command outputs of the sysclk debug slave
interface nios_debug_slave_sysclk_mc_if;
   import nios_debug_slave_sysclk_mc_pkg::*;
   logic              uir_tgl;
   logic              e1dr_tgl;
   logic [IR_W-1:0]   ir_in;
   logic [SR_W-1:0]   sr;
   logic [N_CH-1:0]   ch_done;
   logic              clr_err;
   logic [SR_W-1:0]   jdo;
   logic [N_CH-1:0]   take_action;
   logic [N_CH-1:0]   take_no_action;
   logic              busy;
   logic [LVL_W-1:0]  q_level;
   logic              err_ovf;
   logic              err_tmo;
   modport slave (
      input  uir_tgl, e1dr_tgl, ir_in, sr, ch_done, clr_err,
      output jdo, take_action, take_no_action, busy, q_level, err_ovf, err_tmo
   );
   modport master (
      output uir_tgl, e1dr_tgl, ir_in, sr, ch_done, clr_err,
      input  jdo, take_action, take_no_action, busy, q_level, err_ovf, err_tmo
   );
endinterface

// File: rtl/nios_debug_slave_sysclk_mc_fifo.sv
// nios_debug_slave_sysclk_mc_fifo: synchronous command FIFO with occupancy output; caller gates push/pop
module nios_debug_slave_sysclk_mc_fifo #(
   parameter int W = 8,
   parameter int D = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push_i,
   input  logic [W-1:0]           wdata_i,
   input  logic                   pop_i,
   output logic [W-1:0]           rdata_o,
   output logic [$clog2(D):0]     level_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int AW = $clog2(D);
   localparam int LW = AW + 1;
   logic [W-1:0]  mem_q [D];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [LW-1:0] lvl_q, lvl_d;
   always_comb begin
      wp_d  = push_i ? wp_q + AW'(1) : wp_q;
      rp_d  = pop_i  ? rp_q + AW'(1) : rp_q;
      lvl_d = lvl_q + LW'(push_i) - LW'(pop_i);
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         lvl_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         lvl_q <= lvl_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wp_q] <= wdata_i;
   end
   assign rdata_o = mem_q[rp_q];
   assign level_o = lvl_q;
   assign full_o  = lvl_q == LW'(D);
   assign empty_o = lvl_q == '0;
endmodule

// File: rtl/nios_debug_slave_sysclk_mc.sv
// nios_debug_slave_sysclk_mc: system-clock half of the Nios II debug slave; queues DR snapshots
// and issues per-channel take_action/take_no_action pulses with optional completion handshake.
module nios_debug_slave_sysclk_mc
   import nios_debug_slave_sysclk_mc_pkg::*;
(
   input logic                           clk,
   input logic                           reset_n,
   nios_debug_slave_sysclk_mc_if.slave   bus
);
   state_e            state_q, state_d;
   logic              uir_q, e1dr_q;
   logic [IR_W-1:0]   ir_q, ir_d, ch_q, ch_d, rd_ir;
   logic [SR_W-1:0]   jdo_q, jdo_d, rd_sr;
   logic [N_CH-1:0]   act_q, act_d, nact_q, nact_d, oh;
   logic [TMO_W-1:0]  cnt_q, cnt_d;
   logic              err_ovf_q, err_ovf_d, err_tmo_q, err_tmo_d;
   logic              uir_ev, e1dr_ev, push, pop, ovf, tmo_ev, full, empty;
   logic [LVL_W-1:0]  level;
   assign uir_ev  = bus.uir_tgl ^ uir_q;
   assign e1dr_ev = bus.e1dr_tgl ^ e1dr_q;
   assign pop     = (state_q == S_IDLE) && !empty;
   // A full queue still accepts when the IDLE pop frees a slot in the same cycle
   assign push    = e1dr_ev && (!full || pop);
   assign ovf     = e1dr_ev && !push;
   assign oh      = N_CH'(1) << rd_ir;
   nios_debug_slave_sysclk_mc_fifo #(.W(SR_W + IR_W), .D(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .wdata_i ({ir_q, bus.sr}),
      .pop_i   (pop),
      .rdata_o ({rd_ir, rd_sr}),
      .level_o (level),
      .full_o  (full),
      .empty_o (empty)
   );
   always_comb begin
      state_d = state_q;
      jdo_d   = jdo_q;
      ch_d    = ch_q;
      act_d   = '0;
      nact_d  = '0;
      cnt_d   = cnt_q;
      tmo_ev  = 1'b0;
      case (state_q)
         S_IDLE: if (pop) begin
            state_d = S_ISSUE;
            jdo_d   = rd_sr;
            ch_d    = rd_ir;
            act_d   = rd_sr[ACT_BIT] ? oh : '0;
            nact_d  = rd_sr[ACT_BIT] ? '0 : oh;
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = ACK_MASK[ch_q] ? S_WAIT : S_IDLE;
         end
         S_WAIT: if (bus.ch_done[ch_q]) begin
            state_d = S_IDLE;
         end else if (cnt_q == TMO) begin
            tmo_ev  = 1'b1;
            state_d = S_IDLE;
         end else begin
            cnt_d   = cnt_q + TMO_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
      ir_d      = uir_ev ? bus.ir_in : ir_q;
      err_ovf_d = ovf || (err_ovf_q && !bus.clr_err);
      err_tmo_d = tmo_ev || (err_tmo_q && !bus.clr_err);
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         uir_q     <= bus.uir_tgl;
         e1dr_q    <= bus.e1dr_tgl;
         ir_q      <= '0;
         ch_q      <= '0;
         jdo_q     <= '0;
         act_q     <= '0;
         nact_q    <= '0;
         cnt_q     <= '0;
         err_ovf_q <= 1'b0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         uir_q     <= bus.uir_tgl;
         e1dr_q    <= bus.e1dr_tgl;
         ir_q      <= ir_d;
         ch_q      <= ch_d;
         jdo_q     <= jdo_d;
         act_q     <= act_d;
         nact_q    <= nact_d;
         cnt_q     <= cnt_d;
         err_ovf_q <= err_ovf_d;
         err_tmo_q <= err_tmo_d;
      end
   end
   assign bus.jdo            = jdo_q;
   assign bus.take_action    = act_q;
   assign bus.take_no_action = nact_q;
   assign bus.busy           = (state_q != S_IDLE) || !empty;
   assign bus.q_level        = level;
   assign bus.err_ovf        = err_ovf_q;
   assign bus.err_tmo        = err_tmo_q;
endmodule

// File: tb/tb_nios_debug_slave_sysclk_mc.sv
// tb_nios_debug_slave_sysclk_mc: directed self-checking bench for the sysclk debug slave
module tb_nios_debug_slave_sysclk_mc;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   npulse = 0;
   nios_debug_slave_sysclk_mc_if bus();
   nios_debug_slave_sysclk_mc dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         npulse += $countones(bus.take_action | bus.take_no_action);
      end
   endtask
   task automatic set_ir(input logic [1:0] v);
      bus.ir_in = v;
      bus.uir_tgl = ~bus.uir_tgl;
      tick(1);
   endtask
   task automatic dr(input logic [37:0] v);
      bus.sr = v;
      bus.e1dr_tgl = ~bus.e1dr_tgl;
   endtask
   initial begin
      bus.uir_tgl = 0; bus.e1dr_tgl = 0; bus.ir_in = 0; bus.sr = 0;
      bus.ch_done = 0; bus.clr_err = 0;
      tick(2);
      check("rst_busy", bus.busy, 0);
      check("rst_lvl", bus.q_level, 0);
      check("rst_jdo", bus.jdo, 0);
      check("rst_pulse", {bus.take_action, bus.take_no_action}, 0);
      reset_n = 1;
      tick(1);
      // single acked action on channel 1
      set_ir(2'd1);
      dr(38'h04DEADBEEF);
      tick(1);
      check("t1_c1_act", bus.take_action, 0);
      tick(1);
      check("t1_act", bus.take_action, 4'b0010);
      check("t1_nact", bus.take_no_action, 0);
      check("t1_jdo", bus.jdo, 38'h04DEADBEEF);
      tick(1);
      check("t1_act_off", bus.take_action, 0);
      bus.ch_done = 4'b1101;
      tick(1);
      check("t1_other_done", bus.busy, 1);
      bus.ch_done = 4'b0010;
      tick(1);
      bus.ch_done = 0;
      check("t1_busy", bus.busy, 0);
      // unacked channel 2, three DRs back to back
      set_ir(2'd2);
      dr(38'h0011111111);
      tick(1);
      dr(38'h0422222222);
      tick(1);
      check("t3_nact0", bus.take_no_action, 4'b0100);
      check("t3_jdo0", bus.jdo, 38'h0011111111);
      dr(38'h0033333333);
      tick(1);
      check("t3_gap", {bus.take_action, bus.take_no_action}, 0);
      tick(1);
      check("t3_act1", bus.take_action, 4'b0100);
      check("t3_jdo1", bus.jdo, 38'h0422222222);
      tick(2);
      check("t3_nact2", bus.take_no_action, 4'b0100);
      check("t3_jdo2", bus.jdo, 38'h0033333333);
      // same-cycle IR update and DR uses the old IR
      set_ir(2'd0);
      bus.ir_in = 2'd3;
      bus.uir_tgl = ~bus.uir_tgl;
      dr(38'h04AAAA5555);
      tick(2);
      check("t4_ch0", bus.take_action, 4'b0001);
      check("t4_jdo", bus.jdo, 38'h04AAAA5555);
      bus.ch_done = 4'b0001;
      tick(1);
      bus.ch_done = 0;
      check("t4_issue_done_ign", bus.busy, 1);
      bus.ch_done = 4'b0001;
      tick(1);
      bus.ch_done = 0;
      check("t4_release", bus.busy, 0);
      dr(38'h0012345678);
      tick(2);
      check("t4_ch3", bus.take_no_action, 4'b1000);
      check("t4_jdo3", bus.jdo, 38'h0012345678);
      tick(1);
      // overflow behind an unanswered acked command, then timeout and drain
      set_ir(2'd0);
      dr(38'h0400000001);
      tick(3);
      for (int i = 0; i < 4; i++) begin
         dr(38'h0000000010 + 38'(i));
         tick(1);
      end
      check("t2_lvl4", bus.q_level, 4);
      check("t2_no_ovf", bus.err_ovf, 0);
      dr(38'h00000000FF);
      tick(1);
      check("t2_lvl_full", bus.q_level, 4);
      check("t2_ovf", bus.err_ovf, 1);
      tick(250);
      check("t2_tmo_early", bus.err_tmo, 0);
      tick(1);
      check("t2_tmo", bus.err_tmo, 1);
      npulse = 0;
      bus.ch_done = 4'b0001;
      for (int n = 0; n < 100 && bus.busy; n++) tick(1);
      bus.ch_done = 0;
      check("t2_drain_busy", bus.busy, 0);
      check("t2_drain_lvl", bus.q_level, 0);
      check("t2_drain_pulses", npulse, 4);
      // clear versus coincident overflow
      bus.clr_err = 1;
      tick(1);
      bus.clr_err = 0;
      check("t6_clr_ovf", bus.err_ovf, 0);
      check("t6_clr_tmo", bus.err_tmo, 0);
      dr(38'h0400000002);
      tick(3);
      for (int i = 0; i < 4; i++) begin
         dr(38'h0000000020 + 38'(i));
         tick(1);
      end
      check("t6_pre_ovf", bus.err_ovf, 0);
      dr(38'h00000000EE);
      bus.clr_err = 1;
      tick(1);
      bus.clr_err = 0;
      check("t6_err_wins", bus.err_ovf, 1);
      bus.clr_err = 1;
      tick(1);
      bus.clr_err = 0;
      check("t6_clr_alone", bus.err_ovf, 0);
      // reset while waiting with a full queue
      check("t5_pre_lvl", bus.q_level, 4);
      npulse = 0;
      reset_n = 0;
      tick(1);
      reset_n = 1;
      check("t5_lvl", bus.q_level, 0);
      check("t5_busy", bus.busy, 0);
      check("t5_jdo", bus.jdo, 0);
      tick(6);
      check("t5_no_pulse", npulse, 0);
      check("t5_idle", bus.busy, 0);
      check("t5_lvl_after", bus.q_level, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
